// File: rtl/datatape_pkg.sv
// Shared types and constants for the data-tape receive path (decoder -> deframer).
package datatape_pkg;

  localparam int SYM_W  = 4;
  localparam int BYTE_W = 8;

  // Marker field as {sym_end, sym_begin}, shared with the decoder.
  localparam logic [1:0] MARK_NONE  = 2'b00;
  localparam logic [1:0] MARK_BEGIN = 2'b01;
  localparam logic [1:0] MARK_END   = 2'b10;
  localparam logic [1:0] MARK_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } dfr_state_e;

  function automatic logic [BYTE_W-1:0] csum_next(input logic [BYTE_W-1:0] csum,
                                                  input logic [BYTE_W-1:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/tape_byte_fifo.sv
// Synchronous FIFO for deframed payload bytes; head reads as zero when empty.
module tape_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  // A push into a full FIFO is accepted only when a pop frees the slot that cycle.
  always_comb begin
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty     = (wr_ptr_q == rd_ptr_q);
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_INC;
    else           wr_ptr_d = wr_ptr_q;
    if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_INC;
    else           rd_ptr_d = rd_ptr_q;
    if (empty)     head = '0;
    else           head = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clkin) begin
    if (do_push_s) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tape_deframer.sv
// Nibble-to-byte packet deframer (length, payload, XOR checksum) with byte FIFO output.
// Define TAPE_DEFRAMER_STATS_EN to add saturating good/bad packet counters.
module tape_deframer
  import datatape_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_LEN    = 255
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic [SYM_W-1:0]  sym_in,
  input  logic              sym_valid,
  input  logic              sym_begin,
  input  logic              sym_end,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_last,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              pkt_done,
  output logic              pkt_ok,
  output logic              overflow
`ifdef TAPE_DEFRAMER_STATS_EN
  ,
  output logic [15:0]       good_cnt,
  output logic [15:0]       bad_cnt
`endif
);

  localparam logic [BYTE_W:0] MAX_LEN_W = (BYTE_W+1)'(MAX_LEN);

  dfr_state_e        state_q, state_d;
  logic              phase_q, phase_d;
  logic [SYM_W-1:0]  hi_q, hi_d;
  logic [BYTE_W-1:0] csum_q, csum_d, rem_q, rem_d;
  logic              pkt_drop_q, pkt_drop_d, overflow_q, overflow_d;
  logic              pkt_done_q, pkt_done_d, pkt_ok_q, pkt_ok_d;
  logic [1:0]        mark_s;
  logic [BYTE_W-1:0] byte_s;
  logic              push_s, push_last_s, pop_s, drop_s, full_s, empty_s;
  logic [BYTE_W:0]   head_s;

  // Framing FSM: markers abort or restart, data nibbles pair into bytes.
  always_comb begin
    mark_s      = sym_valid ? {sym_end, sym_begin} : MARK_NONE;
    byte_s      = {hi_q, sym_in};
    pop_s       = !empty_s && byte_ready;
    state_d     = state_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    csum_d      = csum_q;
    rem_d       = rem_q;
    pkt_drop_d  = pkt_drop_q;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = 1'b0;
    push_s      = 1'b0;
    push_last_s = 1'b0;
    case (mark_s)
      MARK_BEGIN: begin
        if (state_q != ST_HUNT) pkt_done_d = 1'b1;
        else                    pkt_done_d = 1'b0;
        state_d    = ST_LEN;
        phase_d    = 1'b0;
        csum_d     = 8'h00;
        pkt_drop_d = 1'b0;
      end
      MARK_END, MARK_BOTH: begin
        if (state_q != ST_HUNT) pkt_done_d = 1'b1;
        else                    pkt_done_d = 1'b0;
        state_d = ST_HUNT;
      end
      default: begin
        if (sym_valid && (state_q != ST_HUNT) && !phase_q) begin
          hi_d    = sym_in;
          phase_d = 1'b1;
        end else if (sym_valid && (state_q != ST_HUNT)) begin
          phase_d = 1'b0;
          case (state_q)
            ST_LEN: begin
              csum_d = csum_next(csum_q, byte_s);
              if ((byte_s == 8'd0) || ({1'b0, byte_s} > MAX_LEN_W)) begin
                pkt_done_d = 1'b1;
                state_d    = ST_HUNT;
              end else begin
                rem_d   = byte_s;
                state_d = ST_PAYLOAD;
              end
            end
            ST_PAYLOAD: begin
              csum_d      = csum_next(csum_q, byte_s);
              push_s      = 1'b1;
              push_last_s = (rem_q == 8'd1);
              rem_d       = rem_q - 8'd1;
              if (rem_q == 8'd1) state_d = ST_CSUM;
              else               state_d = ST_PAYLOAD;
            end
            ST_CSUM: begin
              pkt_done_d = 1'b1;
              pkt_ok_d   = (byte_s == csum_q) && !pkt_drop_q;
              state_d    = ST_HUNT;
            end
            default: state_d = ST_HUNT;
          endcase
        end else begin
          phase_d = phase_q;
        end
      end
    endcase
    drop_s     = push_s && full_s && !pop_s;
    overflow_d = overflow_q | drop_s;
    pkt_drop_d = pkt_drop_d | drop_s;
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      phase_q    <= 1'b0;
      hi_q       <= 4'h0;
      csum_q     <= 8'h00;
      rem_q      <= 8'h00;
      pkt_drop_q <= 1'b0;
      overflow_q <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      csum_q     <= csum_d;
      rem_q      <= rem_d;
      pkt_drop_q <= pkt_drop_d;
      overflow_q <= overflow_d;
      pkt_done_q <= pkt_done_d;
      pkt_ok_q   <= pkt_ok_d;
    end
  end

  tape_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W + 1)
  ) u_fifo (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data ({push_last_s, byte_s}),
    .pop       (pop_s),
    .full      (full_s),
    .empty     (empty_s),
    .head      (head_s)
  );

  assign byte_out   = head_s[BYTE_W-1:0];
  assign byte_last  = head_s[BYTE_W];
  assign byte_valid = !empty_s;
  assign pkt_done   = pkt_done_q;
  assign pkt_ok     = pkt_ok_q;
  assign overflow   = overflow_q;

`ifdef TAPE_DEFRAMER_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;

  // Counters follow the pkt_done pulse and stick at all-ones.
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (pkt_done_q && pkt_ok_q && (good_cnt_q != 16'hFFFF))  good_cnt_d = good_cnt_q + 16'd1;
    else                                                     good_cnt_d = good_cnt_q;
    if (pkt_done_q && !pkt_ok_q && (bad_cnt_q != 16'hFFFF))  bad_cnt_d = bad_cnt_q + 16'd1;
    else                                                     bad_cnt_d = bad_cnt_q;
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      good_cnt_q <= 16'h0000;
      bad_cnt_q  <= 16'h0000;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign good_cnt = good_cnt_q;
  assign bad_cnt  = bad_cnt_q;
`endif

endmodule

// File: tb/tb_tape_deframer.sv
// Self-checking bench for tape_deframer: packet-level reference model, randomized payloads and backpressure.
module tb_tape_deframer;

  localparam int DEPTH = 4;
  localparam int MAXL  = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sym_in;
  logic       sym_valid, sym_begin, sym_end;
  logic [7:0] byte_out;
  logic       byte_last, byte_valid, pkt_done, pkt_ok, overflow;
  logic       ready_fixed, ready_mode, ready_rand;
  logic       byte_ready_s;
`ifdef TAPE_DEFRAMER_STATS_EN
  logic [15:0] good_cnt, bad_cnt;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;
  int exp_good = 0;
  int exp_bad  = 0;

  logic [8:0] got_b[$];
  bit         got_d[$];
  logic [8:0] exp_b[$];
  bit         exp_d[$];
  logic [7:0] pl[0:255];

  assign byte_ready_s = ready_mode ? ready_rand : ready_fixed;

  always #5 clk = ~clk;

  tape_deframer #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL)) dut (
    .clkin(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_begin(sym_begin), .sym_end(sym_end), .byte_out(byte_out),
    .byte_last(byte_last), .byte_valid(byte_valid), .byte_ready(byte_ready_s),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok), .overflow(overflow)
`ifdef TAPE_DEFRAMER_STATS_EN
    , .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
  );

  // Output monitor: records every accepted byte and every status pulse.
  always @(negedge clk) begin
    if (byte_valid === 1'b1 && byte_ready_s === 1'b1) got_b.push_back({byte_last, byte_out});
    if (pkt_done === 1'b1) got_d.push_back(pkt_ok);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ready_rand = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_sym(input logic [3:0] n, input logic b, input logic e, input int gap);
    sym_valid = 1'b1; sym_in = n; sym_begin = b; sym_end = e;
    tick(1);
    sym_valid = 1'b0; sym_begin = 1'b0; sym_end = 1'b0; sym_in = 4'($urandom);
    tick(gap);
  endtask

  task automatic send_byte(input logic [7:0] v, input int maxgap);
    send_sym(v[7:4], 1'b0, 1'b0, $urandom_range(0, maxgap));
    send_sym(v[3:0], 1'b0, 1'b0, $urandom_range(0, maxgap));
  endtask

  // Sends begin/len/payload/csum; when rec is set, appends the expected outcome.
  task automatic send_pkt(input int len, input bit corrupt, input int maxgap, input bit rec);
    logic [7:0] c;
    logic [7:0] lb;
    lb = 8'(len);
    c  = lb;
    for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
    send_sym(4'h0, 1'b1, 1'b0, $urandom_range(0, maxgap));
    send_byte(lb, maxgap);
    for (int i = 0; i < len; i++) begin
      send_byte(pl[i], maxgap);
      c = c ^ pl[i];
      if (rec) exp_b.push_back({(i == len - 1) ? 1'b1 : 1'b0, pl[i]});
    end
    if (corrupt) c = c ^ 8'($urandom_range(1, 255));
    send_byte(c, maxgap);
    if (rec) begin
      exp_d.push_back(!corrupt);
      if (corrupt) exp_bad++; else exp_good++;
    end
  endtask

  task automatic drain();
    ready_mode = 1'b0; ready_fixed = 1'b1;
    for (int i = 0; i < 400 && byte_valid !== 1'b0; i++) tick(1);
    tick(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sym_valid = 1'b0; sym_begin = 1'b0; sym_end = 1'b0; sym_in = 4'h0;
    ready_fixed = 1'b1; ready_mode = 1'b0; ready_rand = 1'b0;
    tick(3);
    rst_n = 1'b1;
    cmp_cnt++;
    if ({byte_valid, byte_out, byte_last, pkt_done, pkt_ok, overflow} !== 13'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got v=%b o=%h l=%b d=%b k=%b ov=%b want all zero",
               byte_valid, byte_out, byte_last, pkt_done, pkt_ok, overflow);
    end
`ifdef TAPE_DEFRAMER_STATS_EN
    cmp_cnt++;
    if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
      err_cnt++; $display("FAIL reset_stats: got %0d/%0d want 0/0", good_cnt, bad_cnt);
    end
`endif
    exp_good = 0; exp_bad = 0;
    tick(2);
  endtask

  task automatic test_basic();
    int bb = got_b.size(); int db = got_d.size();
    exp_b.delete(); exp_d.delete();
    send_sym(4'h0, 1'b1, 1'b0, 0);
    foreach (pl[i]) pl[i] = 8'h00;
    send_byte(8'h02, 1); send_byte(8'h41, 1); send_byte(8'h42, 1); send_byte(8'h01, 1);
    send_sym(4'h0, 1'b1, 1'b0, 0);
    send_byte(8'h02, 1); send_byte(8'h41, 1); send_byte(8'h42, 1); send_byte(8'h00, 1);
    drain();
    exp_b = '{9'h041, 9'h142, 9'h041, 9'h142};
    exp_d = '{1'b1, 1'b0};
    exp_good++; exp_bad++;
    cmp_cnt++;
    if (got_b.size() - bb != exp_b.size() || got_d.size() - db != exp_d.size()) begin
      err_cnt++; $display("FAIL basic_counts: got %0d bytes %0d done want %0d %0d",
                          got_b.size() - bb, got_d.size() - db, exp_b.size(), exp_d.size());
    end
    foreach (exp_b[i]) if (bb + i < got_b.size()) begin
      cmp_cnt++;
      if (got_b[bb+i] !== exp_b[i]) begin err_cnt++; $display("FAIL basic_byte[%0d]: got %h want %h", i, got_b[bb+i], exp_b[i]); end
    end
    foreach (exp_d[i]) if (db + i < got_d.size()) begin
      cmp_cnt++;
      if (got_d[db+i] !== exp_d[i]) begin err_cnt++; $display("FAIL basic_ok[%0d]: got %b want %b", i, got_d[db+i], exp_d[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] hold;
    int bb = got_b.size(); int db = got_d.size();
    exp_b.delete(); exp_d.delete();
    ready_mode = 1'b0; ready_fixed = 1'b0;
    send_pkt(6, 1'b0, 1, 1'b0);
    hold = byte_out;
    tick(4);
    cmp_cnt++;
    if (byte_valid !== 1'b1 || byte_out !== pl[0] || hold !== pl[0] || byte_last !== 1'b0) begin
      err_cnt++; $display("FAIL stall_hold: got v=%b out=%h earlier=%h want v=1 out=%h", byte_valid, byte_out, hold, pl[0]);
    end
    cmp_cnt++;
    if (overflow !== 1'b1) begin err_cnt++; $display("FAIL overflow_flag: got %b want 1", overflow); end
    for (int i = 0; i < DEPTH; i++) exp_b.push_back({1'b0, pl[i]});
    exp_d.push_back(1'b0); exp_bad++;
    drain();
    cmp_cnt++;
    if (got_b.size() - bb != exp_b.size() || got_d.size() - db != exp_d.size()) begin
      err_cnt++; $display("FAIL overflow_counts: got %0d bytes %0d done want %0d %0d",
                          got_b.size() - bb, got_d.size() - db, exp_b.size(), exp_d.size());
    end
    foreach (exp_b[i]) if (bb + i < got_b.size()) begin
      cmp_cnt++;
      if (got_b[bb+i] !== exp_b[i]) begin err_cnt++; $display("FAIL overflow_byte[%0d]: got %h want %h", i, got_b[bb+i], exp_b[i]); end
    end
    if (db < got_d.size()) begin
      cmp_cnt++;
      if (got_d[db] !== 1'b0) begin err_cnt++; $display("FAIL overflow_ok: got %b want 0", got_d[db]); end
    end
  endtask

  task automatic test_aborts();
    logic [7:0] x, y;
    int bb = got_b.size(); int db = got_d.size();
    exp_b.delete(); exp_d.delete();
    x = 8'($urandom); y = 8'($urandom);
    // begin inside PAYLOAD restarts straight into a new length byte
    send_sym(4'h0, 1'b1, 1'b0, 1); send_byte(8'h03, 1); send_byte(x, 1);
    send_sym(4'h0, 1'b1, 1'b0, 1); send_byte(8'h01, 1); send_byte(y, 1); send_byte(8'h01 ^ y, 1);
    exp_b.push_back({1'b0, x}); exp_b.push_back({1'b1, y});
    exp_d.push_back(1'b0); exp_d.push_back(1'b1); exp_bad++; exp_good++;
    // both markers act as end; following nibbles are hunted over
    send_sym(4'h0, 1'b1, 1'b0, 0); send_byte(8'h03, 0); send_byte(x, 0); send_byte(y, 0);
    send_sym(4'h0, 1'b1, 1'b1, 2); send_byte(8'h01, 0); send_byte(8'h55, 0);
    exp_b.push_back({1'b0, x}); exp_b.push_back({1'b0, y}); exp_d.push_back(1'b0); exp_bad++;
    // zero and over-limit lengths, end in HUNT, end in CSUM
    send_sym(4'h0, 1'b1, 1'b0, 0); send_byte(8'h00, 0); send_byte(8'hA5, 0);
    send_sym(4'h0, 1'b1, 1'b0, 0); send_byte(8'(MAXL + 1), 0);
    send_sym(4'h0, 1'b0, 1'b1, 1);
    exp_d.push_back(1'b0); exp_d.push_back(1'b0); exp_bad += 2;
    send_sym(4'h0, 1'b1, 1'b0, 0); send_byte(8'h01, 0); send_byte(x, 0); send_sym(4'h0, 1'b0, 1'b1, 0);
    exp_b.push_back({1'b1, x}); exp_d.push_back(1'b0); exp_bad++;
    send_pkt(MAXL, 1'b0, 0, 1'b1);
    drain();
    cmp_cnt++;
    if (got_b.size() - bb != exp_b.size() || got_d.size() - db != exp_d.size()) begin
      err_cnt++; $display("FAIL abort_counts: got %0d bytes %0d done want %0d %0d",
                          got_b.size() - bb, got_d.size() - db, exp_b.size(), exp_d.size());
    end
    foreach (exp_b[i]) if (bb + i < got_b.size()) begin
      cmp_cnt++;
      if (got_b[bb+i] !== exp_b[i]) begin err_cnt++; $display("FAIL abort_byte[%0d]: got %h want %h", i, got_b[bb+i], exp_b[i]); end
    end
    foreach (exp_d[i]) if (db + i < got_d.size()) begin
      cmp_cnt++;
      if (got_d[db+i] !== exp_d[i]) begin err_cnt++; $display("FAIL abort_ok[%0d]: got %b want %b", i, got_d[db+i], exp_d[i]); end
    end
  endtask

  task automatic test_random_back_to_back();
    int bb = got_b.size(); int db = got_d.size();
    exp_b.delete(); exp_d.delete();
    for (int p = 0; p < 20; p++) begin
      ready_mode = 1'b1;
      send_pkt($urandom_range(1, DEPTH), ($urandom_range(0, 3) == 0), 2, 1'b1);
      drain();
    end
    ready_mode = 1'b0; ready_fixed = 1'b1;
    for (int p = 0; p < 4; p++) send_pkt($urandom_range(5, 30), ($urandom_range(0, 2) == 0), 0, 1'b1);
    drain();
    cmp_cnt++;
    if (got_b.size() - bb != exp_b.size() || got_d.size() - db != exp_d.size()) begin
      err_cnt++; $display("FAIL random_counts: got %0d bytes %0d done want %0d %0d",
                          got_b.size() - bb, got_d.size() - db, exp_b.size(), exp_d.size());
    end
    foreach (exp_b[i]) if (bb + i < got_b.size()) begin
      cmp_cnt++;
      if (got_b[bb+i] !== exp_b[i]) begin err_cnt++; $display("FAIL random_byte[%0d]: got %h want %h", i, got_b[bb+i], exp_b[i]); end
    end
    foreach (exp_d[i]) if (db + i < got_d.size()) begin
      cmp_cnt++;
      if (got_d[db+i] !== exp_d[i]) begin err_cnt++; $display("FAIL random_ok[%0d]: got %b want %b", i, got_d[db+i], exp_d[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int bb, db;
    ready_mode = 1'b0; ready_fixed = 1'b0;
    send_sym(4'h0, 1'b1, 1'b0, 0); send_byte(8'h05, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    tick(1);
    cmp_cnt++;
    if (byte_valid !== 1'b1 || overflow !== 1'b1) begin
      err_cnt++; $display("FAIL pre_reset: got v=%b ov=%b want 1 1", byte_valid, overflow);
    end
`ifdef TAPE_DEFRAMER_STATS_EN
    cmp_cnt++;
    if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
      err_cnt++; $display("FAIL stats_totals: got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad);
    end
`endif
    bb = got_b.size(); db = got_d.size();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_good = 0; exp_bad = 0;
    cmp_cnt++;
    if (byte_valid !== 1'b0 || overflow !== 1'b0 || pkt_done !== 1'b0) begin
      err_cnt++; $display("FAIL mid_reset: got v=%b ov=%b d=%b want 0 0 0", byte_valid, overflow, pkt_done);
    end
`ifdef TAPE_DEFRAMER_STATS_EN
    cmp_cnt++;
    if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
      err_cnt++; $display("FAIL mid_reset_stats: got %0d/%0d want 0/0", good_cnt, bad_cnt);
    end
`endif
    ready_fixed = 1'b1;
    send_byte(8'h01, 0); send_byte(8'h77, 0);
    tick(4);
    cmp_cnt++;
    if (got_b.size() != bb || got_d.size() != db) begin
      err_cnt++; $display("FAIL after_reset_quiet: got %0d bytes %0d done want 0 0", got_b.size() - bb, got_d.size() - db);
    end
    exp_b.delete(); exp_d.delete();
    send_pkt(3, 1'b0, 1, 1'b1);
    drain();
    cmp_cnt++;
    if (got_b.size() - bb != 3 || got_d.size() - db != 1) begin
      err_cnt++; $display("FAIL post_reset_counts: got %0d bytes %0d done want 3 1", got_b.size() - bb, got_d.size() - db);
    end
    foreach (exp_b[i]) if (bb + i < got_b.size()) begin
      cmp_cnt++;
      if (got_b[bb+i] !== exp_b[i]) begin err_cnt++; $display("FAIL post_reset_byte[%0d]: got %h want %h", i, got_b[bb+i], exp_b[i]); end
    end
    if (db < got_d.size()) begin
      cmp_cnt++;
      if (got_d[db] !== 1'b1) begin err_cnt++; $display("FAIL post_reset_ok: got %b want 1", got_d[db]); end
    end
    cmp_cnt++;
    if (overflow !== 1'b0) begin err_cnt++; $display("FAIL post_reset_overflow: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aborts();
    test_random_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
